// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler for a 32 x 32-bit register file: round-robin ALU/LSU
// arbitration onto the single write port plus a pending-destination scoreboard.
module regfile_wb_scheduler #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic [ADDR_W-1:0] iss_rs1,
  input  logic [ADDR_W-1:0] iss_rs2,
  output logic              iss_stall,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] write_select,
  output logic [DATA_W-1:0] data_in,
  output logic [31:0]       pending
);

  localparam int unsigned NREG = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_t;

  src_e              last_grant_q, last_grant_d;
  logic              grant_alu, grant_lsu, grant_any;
  wb_t               wb_sel;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wsel_q, wsel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NREG-1:0]   pend_q, pend_d;
  logic              hazard;
  logic              issue_fire;

  // Round-robin arbiter: under contention the requester not granted last wins.
  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    if (alu_valid && lsu_valid) begin
      if (last_grant_q == SRC_LSU) grant_alu = 1'b1;
      else                         grant_lsu = 1'b1;
    end else begin
      grant_alu = alu_valid;
      grant_lsu = lsu_valid;
    end
  end

  assign grant_any = grant_alu | grant_lsu;
  assign alu_ready = grant_alu;
  assign lsu_ready = grant_lsu;

  always_comb begin
    wb_sel.rd   = alu_rd;
    wb_sel.data = alu_data;
    if (grant_lsu) begin
      wb_sel.rd   = lsu_rd;
      wb_sel.data = lsu_data;
    end
  end

  // Write stage: a granted rd=0 transaction is consumed but never enables the write.
  always_comb begin
    last_grant_d = last_grant_q;
    wr_en_d      = 1'b0;
    wsel_d       = wsel_q;
    wdata_d      = wdata_q;
    if (grant_alu)      last_grant_d = SRC_ALU;
    else if (grant_lsu) last_grant_d = SRC_LSU;
    if (grant_any) begin
      wr_en_d = (wb_sel.rd != '0);
      wsel_d  = wb_sel.rd;
      wdata_d = wb_sel.data;
    end
  end

  // Stall depends only on issue inputs and scoreboard state, never on producers.
  assign hazard     = pend_q[iss_rs1] | pend_q[iss_rs2] | pend_q[iss_rd];
  assign iss_stall  = iss_valid & hazard;
  assign issue_fire = iss_valid & ~hazard;

  // Clear lands with the register-file commit; a same-edge set takes priority.
  always_comb begin
    pend_d = pend_q;
    if (wr_en_q) pend_d[wsel_q] = 1'b0;
    if (issue_fire && (iss_rd != '0)) pend_d[iss_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= SRC_LSU;
      wr_en_q      <= 1'b0;
      wsel_q       <= '0;
      wdata_q      <= '0;
      pend_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wsel_q       <= wsel_d;
      wdata_q      <= wdata_d;
      pend_q       <= pend_d;
    end
  end

  assign WR_EN        = wr_en_q;
  assign write_select = wsel_q;
  assign data_in      = wdata_q;
  assign pending      = pend_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios then random traffic, all
// checked against a cycle-level model of the arbitration and scoreboard rules.
module tb_regfile_wb_scheduler;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int ALU = 0;
  localparam int LSU = 1;

  logic              clock;
  logic              reset_n;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rd, iss_rs1, iss_rs2;
  logic              iss_stall;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              lsu_valid;
  logic [ADDR_W-1:0] lsu_rd;
  logic [DATA_W-1:0] lsu_data;
  logic              lsu_ready;
  logic              WR_EN;
  logic [ADDR_W-1:0] write_select;
  logic [DATA_W-1:0] data_in;
  logic [31:0]       pending;

  regfile_wb_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_stall(iss_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .WR_EN(WR_EN), .write_select(write_select), .data_in(data_in), .pending(pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0]       m_pend;
  int                m_last;
  logic              m_we;
  logic [ADDR_W-1:0] m_sel;
  logic [DATA_W-1:0] m_din;
  int                outq[$];

  // Observations from the last step
  logic obs_stall, obs_alu, obs_lsu;
  bit   last_ga, last_gl;

  // External register file fed from the DUT write port
  logic [DATA_W-1:0] rf [32];
  always @(posedge clock)
    if (WR_EN && write_select != '0) rf[write_select] <= data_in;

  always @(posedge clock)
    if (reset_n)
      assert (!(WR_EN && iss_valid && !iss_stall && iss_rd == write_select && iss_rd != '0))
        else $error("FAIL set_clear_collision sel=%0d", write_select);

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0;
    m_last = LSU;
    m_we   = 1'b0;
    m_sel  = '0;
    m_din  = '0;
    outq.delete();
  endtask

  task automatic idle_inputs();
    iss_valid = 1'b0; iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
  endtask

  // One clock cycle: check combinational outputs, cross the edge, check state.
  task automatic step();
    bit exp_stall, fire, ga, gl;
    #2;
    exp_stall = iss_valid && (m_pend[iss_rs1] || m_pend[iss_rs2] || m_pend[iss_rd]);
    if (alu_valid && lsu_valid) begin
      ga = (m_last == LSU);
      gl = (m_last == ALU);
    end else begin
      ga = alu_valid;
      gl = lsu_valid;
    end
    check_eq("iss_stall", 64'(iss_stall), 64'(exp_stall));
    check_eq("alu_ready", 64'(alu_ready), 64'(ga));
    check_eq("lsu_ready", 64'(lsu_ready), 64'(gl));
    obs_stall = iss_stall; obs_alu = alu_ready; obs_lsu = lsu_ready;
    last_ga = ga; last_gl = gl;
    fire = iss_valid && !exp_stall;
    @(posedge clock);
    #1;
    if (m_we) m_pend[m_sel] = 1'b0;
    if (fire && iss_rd != '0) begin
      m_pend[iss_rd] = 1'b1;
      outq.push_back(int'(iss_rd));
    end
    if (ga) begin
      m_we = (alu_rd != '0); m_sel = alu_rd; m_din = alu_data; m_last = ALU;
    end else if (gl) begin
      m_we = (lsu_rd != '0); m_sel = lsu_rd; m_din = lsu_data; m_last = LSU;
    end else begin
      m_we = 1'b0;
    end
    check_eq("WR_EN", 64'(WR_EN), 64'(m_we));
    check_eq("write_select", 64'(write_select), 64'(m_sel));
    check_eq("data_in", 64'(data_in), 64'(m_din));
    check_eq("pending", 64'(pending), 64'(m_pend));
  endtask

  initial begin
    bit drained;
    idle_inputs();
    model_reset();
    reset_n = 1'b0;
    #3;
    check_eq("rst_wr_en", 64'(WR_EN), 64'd0);
    check_eq("rst_sel", 64'(write_select), 64'd0);
    check_eq("rst_din", 64'(data_in), 64'd0);
    check_eq("rst_pending", 64'(pending), 64'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Contention: both producers busy for 4 cycles, ALU first after reset.
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA000_0000;
    lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 32'hB000_0000;
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq($sformatf("rr_alu_%0d", k), 64'(obs_alu), 64'((k % 2) == 0));
      check_eq($sformatf("rr_lsu_%0d", k), 64'(obs_lsu), 64'((k % 2) == 1));
      check_eq($sformatf("rr_wr_en_%0d", k), 64'(WR_EN), 64'd1);
      if (obs_alu) begin alu_rd = 5'(12 + k); alu_data = 32'hA000_0001 + 32'(k); end
      if (obs_lsu) begin lsu_rd = 5'(16 + k); lsu_data = 32'hB000_0001 + 32'(k); end
    end
    idle_inputs();
    step();

    // Single ALU write to x5.
    iss_valid = 1'b1; iss_rd = 5'd5; iss_rs1 = 5'd1; iss_rs2 = 5'd2;
    step();
    check_eq("alu1_pending_set", 64'(pending), 64'h20);
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    check_eq("alu1_ready", 64'(obs_alu), 64'd1);
    check_eq("alu1_wr_en", 64'(WR_EN), 64'd1);
    check_eq("alu1_sel", 64'(write_select), 64'd5);
    check_eq("alu1_din", 64'(data_in), 64'hDEADBEEF);
    idle_inputs();
    step();
    check_eq("alu1_pending_clr", 64'(pending), 64'd0);

    // RAW: consumer of x7 stalls until the cycle after the WR_EN cycle.
    iss_valid = 1'b1; iss_rd = 5'd7; iss_rs1 = 5'd1; iss_rs2 = 5'd2;
    step();
    iss_rd = 5'd8; iss_rs1 = 5'd7; iss_rs2 = 5'd0;
    step();
    check_eq("raw_stall_wait", 64'(obs_stall), 64'd1);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h1234_5678;
    step();
    check_eq("raw_stall_grant", 64'(obs_stall), 64'd1);
    alu_valid = 1'b0;
    step();
    check_eq("raw_stall_wb", 64'(obs_stall), 64'd1);
    step();
    check_eq("raw_release", 64'(obs_stall), 64'd0);
    check_eq("raw_rf_x7", 64'(rf[7]), 64'h1234_5678);
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h8888_8888;
    step();
    idle_inputs();
    step();
    step();

    // WAW on x3, x0 destination, x0 write-back.
    iss_valid = 1'b1; iss_rd = 5'd3; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
    step();
    step();
    check_eq("waw_stall", 64'(obs_stall), 64'd1);
    iss_rd = 5'd0;
    step();
    check_eq("x0_no_stall", 64'(obs_stall), 64'd0);
    check_eq("x0_pending", 64'(pending), 64'h8);
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3333_3333;
    step();
    idle_inputs();
    step();
    step();
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hAAAA_AAAA;
    step();
    check_eq("x0_lsu_ready", 64'(obs_lsu), 64'd1);
    check_eq("x0_wr_en", 64'(WR_EN), 64'd0);
    idle_inputs();
    step();

    // Unissued write-back to x9.
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h9999_0009;
    step();
    check_eq("unissued_wr_en", 64'(WR_EN), 64'd1);
    check_eq("unissued_sel", 64'(write_select), 64'd9);
    idle_inputs();
    step();
    check_eq("unissued_pending", 64'(pending), 64'd0);

    // Reset in the middle of a write.
    iss_valid = 1'b1; iss_rd = 5'd4; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hCAFE_F00D;
    step();
    check_eq("midrst_pre_wr_en", 64'(WR_EN), 64'd1);
    check_eq("midrst_pre_pending", 64'(pending), 64'h10);
    idle_inputs();
    reset_n = 1'b0;
    #1;
    check_eq("midrst_wr_en", 64'(WR_EN), 64'd0);
    check_eq("midrst_sel", 64'(write_select), 64'd0);
    check_eq("midrst_din", 64'(data_in), 64'd0);
    check_eq("midrst_pending", 64'(pending), 64'd0);
    model_reset();
    #2;
    reset_n = 1'b1;

    // Random traffic: every issued destination is written back exactly once.
    for (int c = 0; c < 2500; c++) begin
      iss_valid = ($urandom_range(9, 0) < 6);
      iss_rd    = 5'($urandom_range(7, 0));
      iss_rs1   = 5'($urandom_range(9, 0));
      iss_rs2   = 5'($urandom_range(9, 0));
      if (!alu_valid) begin
        if (outq.size() > 0 && $urandom_range(1, 0) == 1) begin
          alu_valid = 1'b1; alu_rd = 5'(outq.pop_front()); alu_data = $urandom;
        end else if ($urandom_range(15, 0) == 0) begin
          alu_valid = 1'b1; alu_rd = '0; alu_data = $urandom;
        end
      end
      if (!lsu_valid) begin
        if (outq.size() > 0 && $urandom_range(2, 0) == 0) begin
          lsu_valid = 1'b1; lsu_rd = 5'(outq.pop_front()); lsu_data = $urandom;
        end else if ($urandom_range(15, 0) == 0) begin
          lsu_valid = 1'b1; lsu_rd = '0; lsu_data = $urandom;
        end
      end
      step();
      if (last_ga) alu_valid = 1'b0;
      if (last_gl) lsu_valid = 1'b0;
    end

    // Drain outstanding write-backs with issue idle.
    iss_valid = 1'b0;
    drained = 1'b0;
    for (int c = 0; c < 300 && !drained; c++) begin
      if (!alu_valid && outq.size() > 0) begin
        alu_valid = 1'b1; alu_rd = 5'(outq.pop_front()); alu_data = $urandom;
      end
      step();
      if (last_ga) alu_valid = 1'b0;
      if (last_gl) lsu_valid = 1'b0;
      drained = (outq.size() == 0) && !alu_valid && !lsu_valid && (m_pend == '0) && !m_we;
    end
    check_eq("drain_done", 64'(drained), 64'd1);
    check_eq("drain_pending", 64'(pending), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-back scheduler and scoreboard for the 32 x 32-bit register file (two registered read ports, one write port, x0 hard-wired to zero). Two result producers, the ALU and the load/store unit, share the single write port through a round-robin arbiter with a valid/ready handshake. A 32-entry pending-destination scoreboard tells the issue stage when an instruction must stall. The stall covers RAW hazards on its sources and WAW hazards on its destination, until the in-flight write has actually landed in the register file.

## Interface
- DATA_W, 32, write-data width
- ADDR_W, 5, register index width (32 registers)

- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- iss_valid  in  1  issue stage presents an instruction that writes a register
- iss_rd  in  ADDR_W  destination index of the issuing instruction
- iss_rs1  in  ADDR_W  source 1 index
- iss_rs2  in  ADDR_W  source 2 index
- iss_stall  out  1  issue must hold this cycle (combinational)
- alu_valid  in  1  ALU result available
- alu_rd  in  ADDR_W  ALU destination index
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU result accepted this cycle (combinational)
- lsu_valid  in  1  load result available
- lsu_rd  in  ADDR_W  load destination index
- lsu_data  in  DATA_W  load result
- lsu_ready  out  1  load result accepted this cycle (combinational)
- WR_EN  out  1  register-file write enable (registered)
- write_select  out  ADDR_W  register-file write index (registered)
- data_in  out  DATA_W  register-file write data (registered)
- pending  out  32  scoreboard bit vector; bit i = write to xi outstanding

## Operation
- Reset values:
  - WR_EN=0, write_select=0, data_in=0, pending=0.
  - Round-robin pointer last_grant=LSU, so the ALU wins the first contention.
- Arbitration (combinational grant):
  - Only one valid → that requester is granted.
  - Both valid → the requester other than last_grant is granted.
  - Neither valid → no grant, last_grant unchanged.
  - alu_ready/lsu_ready = own grant. A requester holds valid, rd and data stable until ready is sampled high.
  - last_grant updates only on an actual grant.
- Write stage (registered):
  - On a grant, the next edge loads write_select←rd and data_in←data.
  - On the same edge, WR_EN←1 if rd≠0, else WR_EN←0. The transaction is still consumed and the rd=0 write is dropped.
  - No grant → WR_EN←0, write_select/data_in hold their values.
  - The register file has no backpressure: one write per cycle, sustained.
- Scoreboard:
  - Issue fires when iss_valid=1 and iss_stall=0. At the edge, pending[iss_rd]←1 unless iss_rd=0.
  - iss_stall = iss_valid & (pending[iss_rs1] | pending[iss_rs2] | pending[iss_rd]). pending[0] is always 0.
  - Clear: at an edge where WR_EN=1, pending[write_select]←0. This is the same edge on which the register file commits the write. A read selected after that edge returns the new value, because register-file reads are themselves registered.
  - Set and clear of the same index on one edge → set wins. This is unreachable under the WAW stall and is asserted in the bench.
  - A write-back to an index whose pending bit is 0 is written normally; the clear is a no-op.
- Reset mid-operation: all state returns to reset values immediately. In-flight writes and pending bits are discarded.

## Timing
- Handshake latency:
  - Grant at cycle N → WR_EN/write_select/data_in valid in cycle N+1.
  - Register file updated at the end of N+1.
  - pending bit cleared at the end of N+1.
- Stall release: iss_stall deasserts in cycle N+2.
  - At that edge the issue stage presents rs select lines; reg_1/reg_2 return the new value in N+3.
- Issue → scoreboard: a set at the end of cycle M is visible to iss_stall in M+1. Back-to-back dependent issues therefore stall.
- iss_stall and the ready signals are combinational from inputs and state. There is no combinational path from alu_*/lsu_* to iss_stall.

## Test plan
- Reset: drive reset_n=0 mid-write (WR_EN=1, pending=0x0000_0010) → WR_EN, write_select and data_in all 0 and pending=0 within the same cycle, no edge needed.
- Single ALU write: issue rd=5, then alu_valid with rd=5, data=0xDEADBEEF.
  - Issue: pending=0x20.
  - Grant: alu_ready=1.
  - Next cycle: WR_EN=1, write_select=5, data_in=0xDEADBEEF.
  - Following cycle: pending=0.
- Contention fairness: alu_valid and lsu_valid held high for 4 cycles → grants alternate ALU, LSU, ALU, LSU; WR_EN stays high for 4 consecutive cycles.
- RAW stall: issue rd=7 (issue fires); next instruction has rs1=7.
  - iss_stall stays 1 until the cycle after the write-back's WR_EN cycle, then drops.
  - A read of x7 after release returns the written value.
- WAW and x0:
  - Issue rd=3 with pending[3]=1 → iss_stall=1.
  - Issue rd=0 → no stall, pending unchanged.
  - LSU write-back with rd=0 → lsu_ready=1, WR_EN stays 0.
- Unissued write-back: lsu rd=9 with pending=0 → WR_EN=1, write_select=9, pending stays 0.
